// File: rtl/hazard_stall_ctrl.sv
// Load-use hazard controller for a 5-stage RISC-V pipeline: detects load-use
// hazards, inserts LU_CYCLES bubbles, lets taken branches flush and dmem_busy freeze.
module hazard_stall_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int LU_CYCLES  = 1,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] id_ex_rd,
  input  logic [REG_ADDR_W-1:0] if_id_rs1,
  input  logic [REG_ADDR_W-1:0] if_id_rs2,
  input  logic                  if_id_use_rs1,
  input  logic                  if_id_use_rs2,
  input  logic                  branch_taken,
  input  logic                  dmem_busy,
  input  logic                  stat_clr,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic                  pipe_hold,
  output logic                  stall,
  output logic [CNT_W-1:0]      stall_events
);

  localparam int CW = (LU_CYCLES > 1) ? $clog2(LU_CYCLES + 1) : 1;

  typedef enum logic {RUN = 1'b0, LU_STALL = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0] ev_q, ev_d;
  logic            hz;
  logic            ev_inc;

  // Load-use hazard: x0 never creates a dependency, unused operands are ignored
  always_comb begin
    hz = id_ex_mem_read && (id_ex_rd != {REG_ADDR_W{1'b0}}) &&
         ((if_id_use_rs1 && (if_id_rs1 == id_ex_rd)) ||
          (if_id_use_rs2 && (if_id_rs2 == id_ex_rd)));
  end

  // Next-state and output decode; reset forces the run pattern regardless of inputs
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ev_inc       = 1'b0;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_hold    = 1'b0;
    stall        = 1'b0;
    if (!rst_n) begin
      state_d = RUN;
      cnt_d   = {CW{1'b0}};
    end else if (dmem_busy) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      pipe_hold   = 1'b1;
    end else if (branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      state_d      = RUN;
      cnt_d        = {CW{1'b0}};
    end else begin
      case (state_q)
        LU_STALL: begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
          stall        = 1'b1;
          cnt_d        = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = RUN;
          end else begin
            state_d = LU_STALL;
          end
        end
        RUN: begin
          if (hz) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            stall        = 1'b1;
            ev_inc       = 1'b1;
            // A single-bubble configuration never leaves RUN
            if (LU_CYCLES > 1) begin
              state_d = LU_STALL;
              cnt_d   = CW'(LU_CYCLES - 1);
            end else begin
              state_d = RUN;
            end
          end else begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = {CW{1'b0}};
        end
      endcase
    end
  end

  // Saturating stall-entry counter; clear beats a coinciding increment
  always_comb begin
    ev_d = ev_q;
    if (stat_clr) begin
      ev_d = {CNT_W{1'b0}};
    end else if (ev_inc && !(&ev_q)) begin
      ev_d = ev_q + CNT_W'(1);
    end else begin
      ev_d = ev_q;
    end
  end

  // State, bubble counter and statistics registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= {CW{1'b0}};
      ev_q    <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ev_q    <= ev_d;
    end
  end

  assign stall_events = ev_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: one instance with LU_CYCLES=1/CNT_W=16
// and one with LU_CYCLES=3/CNT_W=2, driven by shared stimulus.
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_ex_mem_read;
  logic [4:0] id_ex_rd, if_id_rs1, if_id_rs2;
  logic       if_id_use_rs1, if_id_use_rs2;
  logic       branch_taken, dmem_busy, stat_clr;

  logic a_pc, a_ifw, a_fl, a_bub, a_hold, a_st;
  logic b_pc, b_ifw, b_fl, b_bub, b_hold, b_st;
  logic [15:0] a_ev;
  logic [1:0]  b_ev;
  logic [5:0]  oa, ob;

  int n_pass = 0;
  int n_tot  = 0;

  // {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold, stall}
  localparam logic [5:0] P_DEF = 6'b110000;
  localparam logic [5:0] P_STL = 6'b000101;
  localparam logic [5:0] P_FRZ = 6'b000010;
  localparam logic [5:0] P_FLS = 6'b111100;

  always #5 clk = ~clk;

  assign oa = {a_pc, a_ifw, a_fl, a_bub, a_hold, a_st};
  assign ob = {b_pc, b_ifw, b_fl, b_bub, b_hold, b_st};

  hazard_stall_ctrl #(.REG_ADDR_W(5), .LU_CYCLES(1), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2), .if_id_use_rs1(if_id_use_rs1),
    .if_id_use_rs2(if_id_use_rs2), .branch_taken(branch_taken), .dmem_busy(dmem_busy),
    .stat_clr(stat_clr), .pc_write(a_pc), .if_id_write(a_ifw), .if_id_flush(a_fl),
    .id_ex_bubble(a_bub), .pipe_hold(a_hold), .stall(a_st), .stall_events(a_ev));

  hazard_stall_ctrl #(.REG_ADDR_W(5), .LU_CYCLES(3), .CNT_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2), .if_id_use_rs1(if_id_use_rs1),
    .if_id_use_rs2(if_id_use_rs2), .branch_taken(branch_taken), .dmem_busy(dmem_busy),
    .stat_clr(stat_clr), .pc_write(b_pc), .if_id_write(b_ifw), .if_id_flush(b_fl),
    .id_ex_bubble(b_bub), .pipe_hold(b_hold), .stall(b_st), .stall_events(b_ev));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tot++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check both instances' enables mid-cycle, then advance past the next edge
  task automatic step(input string tag, input logic [5:0] ea, input logic [5:0] eb);
    @(negedge clk);
    chk({tag, "_A"}, {10'd0, oa}, {10'd0, ea});
    chk({tag, "_B"}, {10'd0, ob}, {10'd0, eb});
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ev(input string tag, input logic [15:0] ea, input logic [1:0] eb);
    chk({tag, "_evA"}, a_ev, ea);
    chk({tag, "_evB"}, {14'd0, b_ev}, {14'd0, eb});
  endtask

  task automatic set_hz(input logic on);
    id_ex_mem_read = on;
    id_ex_rd       = 5'd5;
    if_id_rs1      = 5'd5;
    if_id_rs2      = 5'd1;
    if_id_use_rs1  = 1'b1;
    if_id_use_rs2  = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    branch_taken = 1'b0; dmem_busy = 1'b0; stat_clr = 1'b0;
    set_hz(1'b1);
    // Reset: outputs forced to the run pattern even with a hazard present
    step("rst", P_DEF, P_DEF);
    chk_ev("rst", 16'd0, 2'd0);
    set_hz(1'b0);
    rst_n = 1'b1;
    step("idle", P_DEF, P_DEF);

    // ld x5; add x6,x5,x1 -- single cycle hazard
    set_hz(1'b1);
    step("lu1_c1", P_STL, P_STL);
    set_hz(1'b0);
    step("lu1_c2", P_DEF, P_STL);
    chk_ev("lu1", 16'd1, 2'd1);
    step("lu1_c3", P_DEF, P_STL);
    step("lu1_c4", P_DEF, P_DEF);

    // Hazard held for three cycles: B stalls exactly three cycles, one entry
    set_hz(1'b1);
    step("hold_c1", P_STL, P_STL);
    step("hold_c2", P_STL, P_STL);
    chk_ev("hold_mid", 16'd3, 2'd2);
    step("hold_c3", P_STL, P_STL);
    set_hz(1'b0);
    step("hold_c4", P_DEF, P_DEF);
    chk_ev("hold", 16'd4, 2'd2);

    // Filtering: x0 destination, and unused rs2 match
    id_ex_mem_read = 1'b1; id_ex_rd = 5'd0; if_id_rs1 = 5'd0; if_id_use_rs1 = 1'b1;
    step("x0", P_DEF, P_DEF);
    id_ex_rd = 5'd7; if_id_rs1 = 5'd3; if_id_rs2 = 5'd7; if_id_use_rs2 = 1'b0;
    step("unused_rs2", P_DEF, P_DEF);
    if_id_use_rs2 = 1'b1;
    step("rs2_hit", P_STL, P_STL);
    set_hz(1'b0);
    step("rs2_c2", P_DEF, P_STL);
    step("rs2_c3", P_DEF, P_STL);
    chk_ev("rs2", 16'd5, 2'd3);

    // Branch on the second stall cycle cancels the stall; B counter saturated
    set_hz(1'b1);
    step("br_c1", P_STL, P_STL);
    set_hz(1'b0);
    branch_taken = 1'b1;
    step("br_c2", P_FLS, P_FLS);
    branch_taken = 1'b0;
    step("br_c3", P_DEF, P_DEF);
    chk_ev("br_sat", 16'd6, 2'd3);

    // Busy beats branch
    dmem_busy = 1'b1; branch_taken = 1'b1;
    step("busy_br", P_FRZ, P_FRZ);
    dmem_busy = 1'b0;
    step("br_after", P_FLS, P_FLS);
    branch_taken = 1'b0;

    // Freeze for four cycles with cnt=2, then the two remaining stall cycles
    set_hz(1'b1);
    step("frz_c1", P_STL, P_STL);
    set_hz(1'b0);
    dmem_busy = 1'b1;
    for (int i = 0; i < 4; i++) step("frz_hold", P_FRZ, P_FRZ);
    dmem_busy = 1'b0;
    step("frz_s2", P_DEF, P_STL);
    step("frz_s3", P_DEF, P_STL);
    step("frz_end", P_DEF, P_DEF);
    chk_ev("frz", 16'd7, 2'd3);

    // Clear wins over a coinciding increment
    set_hz(1'b1); stat_clr = 1'b1;
    step("clr_c1", P_STL, P_STL);
    set_hz(1'b0); stat_clr = 1'b0;
    chk_ev("clr", 16'd0, 2'd0);
    // Asynchronous reset in the middle of B's stall
    #2 rst_n = 1'b0;
    #1;
    chk("arst_A", {10'd0, oa}, {10'd0, P_DEF});
    chk("arst_B", {10'd0, ob}, {10'd0, P_DEF});
    @(posedge clk); #1;
    rst_n = 1'b1;
    step("post_rst", P_DEF, P_DEF);
    chk_ev("post_rst", 16'd0, 2'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
